// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// FSM state encoding and default latencies.
package md_defs;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } mdOpT;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DIV_BUSY = 2'd2
   } mdStateT;

   // Codes 9-15 are unused and must behave exactly like MD_NONE.
   function automatic logic isMdOp(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational multiply/divide datapath. Produces {hi,lo} for the latched
// operation and flags a zero divisor so the caller can skip the write.
module md_arith
   import md_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   input  logic [3:0]         opKind,
   output logic [2*WIDTH-1:0] result,
   output logic               divByZero
);

   logic [2*WIDTH-1:0] extA, extB, prodS, prodU;
   logic [WIDTH-1:0]   safeB, magA, magB, qMag, rMag, qSigned, rSigned, qUns, rUns;
   logic               negA, negB, isDiv;

   assign isDiv     = (opKind == MD_DIV) || (opKind == MD_DIVU);
   assign divByZero = isDiv && (opB == '0);
   assign safeB     = (opB == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : opB;

   // Full-width products; sign extension makes the low 2*WIDTH bits exact.
   assign extA  = {{WIDTH{opA[WIDTH-1]}}, opA};
   assign extB  = {{WIDTH{opB[WIDTH-1]}}, opB};
   assign prodS = extA * extB;
   assign prodU = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};

   // Signed division on magnitudes; the most-negative / -1 case wraps to
   // itself with a zero remainder without special handling.
   assign negA    = opA[WIDTH-1];
   assign negB    = safeB[WIDTH-1];
   assign magA    = negA ? -opA : opA;
   assign magB    = negB ? -safeB : safeB;
   assign qMag    = magA / magB;
   assign rMag    = magA % magB;
   assign qSigned = (negA ^ negB) ? -qMag : qMag;
   assign rSigned = negA ? -rMag : rMag;
   assign qUns    = opA / safeB;
   assign rUns    = opA % safeB;

   always_comb begin
      result = '0;
      case (opKind)
         MD_MULT:  result = prodS;
         MD_MULTU: result = prodU;
         MD_DIV:   result = {rSigned, qSigned};
         MD_DIVU:  result = {rUns, qUns};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers for the
// E stage; requests a stall while a following MD instruction must wait.
module mul_div_unit
   import md_defs::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       md_op,
   input  logic             start,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] md_rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   mdStateT            state, nextState;
   logic [CNT_W-1:0]   cnt, nextCnt;
   logic [WIDTH-1:0]   opA, opB, nextOpA, nextOpB;
   logic [WIDTH-1:0]   hiReg, loReg, nextHi, nextLo;
   logic [3:0]         opKind, nextOpKind;
   logic [2*WIDTH-1:0] arithResult;
   logic               divByZero;
   logic               mdUse;

   assign mdUse     = start && isMdOp(md_op);
   assign busy      = (state != IDLE);
   // A new op is accepted on the edge it appears while IDLE, so only a
   // second MD instruction arriving during the busy window is held.
   assign stall_req = mdUse && busy;
   assign hi        = hiReg;
   assign lo        = loReg;

   always_comb begin
      md_rdata = '0;
      if (md_op == MD_MFHI)
         md_rdata = hiReg;
      else if (md_op == MD_MFLO)
         md_rdata = loReg;
   end

   md_arith #(.WIDTH(WIDTH)) uArith (
      .opA       (opA),
      .opB       (opB),
      .opKind    (opKind),
      .result    (arithResult),
      .divByZero (divByZero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         opA    <= '0;
         opB    <= '0;
         opKind <= MD_NONE;
         hiReg  <= '0;
         loReg  <= '0;
      end else begin
         state  <= nextState;
         cnt    <= nextCnt;
         opA    <= nextOpA;
         opB    <= nextOpB;
         opKind <= nextOpKind;
         hiReg  <= nextHi;
         loReg  <= nextLo;
      end
   end

   always_comb begin
      nextState  = state;
      nextCnt    = cnt;
      nextOpA    = opA;
      nextOpB    = opB;
      nextOpKind = opKind;
      nextHi     = hiReg;
      nextLo     = loReg;
      case (state)
         IDLE: begin
            if (mdUse) begin
               case (md_op)
                  MD_MULT, MD_MULTU: begin
                     nextState  = MUL_BUSY;
                     nextCnt    = CNT_W'(MULT_CYCLES);
                     nextOpA    = rs_val;
                     nextOpB    = rt_val;
                     nextOpKind = md_op;
                  end
                  MD_DIV, MD_DIVU: begin
                     nextState  = DIV_BUSY;
                     nextCnt    = CNT_W'(DIV_CYCLES);
                     nextOpA    = rs_val;
                     nextOpB    = rt_val;
                     nextOpKind = md_op;
                  end
                  MD_MTHI: nextHi = rs_val;
                  MD_MTLO: nextLo = rs_val;
                  default: ;
               endcase
            end
         end
         MUL_BUSY, DIV_BUSY: begin
            nextCnt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               nextState = IDLE;
               // A zero divisor still burns the full latency but leaves HI/LO alone.
               if (!divByZero)
                  {nextHi, nextLo} = arithResult;
            end
         end
         default: begin
            nextState = IDLE;
            nextCnt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results, stall behaviour
// and reset abort, each scenario checked against hand-computed values.
module tb_mul_div_unit;

   localparam int W = 32;
   localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                          OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                          OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   md_op = 4'd0;
   logic         start = 1'b0;
   logic [W-1:0] rs_val = '0;
   logic [W-1:0] rt_val = '0;
   logic         busy, stall_req;
   logic [W-1:0] md_rdata, hi, lo;

   int checks = 0;
   int failures = 0;

   mul_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .md_op     (md_op),
      .start     (start),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .busy      (busy),
      .stall_req (stall_req),
      .md_rdata  (md_rdata),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Present an op for one accepting edge; returns at the negedge after it.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0; md_op = OP_NONE;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 64) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b1; md_op = OP_MFHI; #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
      checks++; if (md_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", md_rdata); end
      checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
      start = 1'b0; md_op = OP_NONE;
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int n;
      issue(OP_MULT, 32'hFFFFFFFE, 32'h3);
      // A non-MD instruction in E while busy must not stall.
      start = 1'b1; md_op = OP_NONE; #1;
      checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mult_nonmd_stall got=%0b exp=0", stall_req); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mult_hi_early got=%h exp=0", hi); end
      start = 1'b0;
      count_busy(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
   endtask

   task automatic test_multu;
      int n;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
      count_busy(n);
      checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
   endtask

   task automatic test_div;
      int n;
      issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
      count_busy(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
      checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
   endtask

   task automatic test_divu;
      int n;
      issue(OP_DIVU, 32'hFFFFFFFF, 32'h10);
      count_busy(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
      checks++; if (lo !== 32'h0FFFFFFF) begin failures++; $display("FAIL divu_lo got=%h exp=0fffffff", lo); end
      checks++; if (hi !== 32'h0000000F) begin failures++; $display("FAIL divu_hi got=%h exp=0000000f", hi); end
   endtask

   task automatic test_div_overflow;
      int n;
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      count_busy(n);
      checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL divovf_hi got=%h exp=0", hi); end
   endtask

   task automatic test_div_by_zero;
      int n;
      issue(OP_MTHI, 32'h1234, 32'h0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
      checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi_hi got=%h exp=1234", hi); end
      issue(OP_MTLO, 32'h5678, 32'h0);
      checks++; if (lo !== 32'h5678) begin failures++; $display("FAIL mtlo_lo got=%h exp=5678", lo); end
      issue(OP_DIV, 32'h64, 32'h0);
      count_busy(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
      checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL div0_hi got=%h exp=1234", hi); end
      checks++; if (lo !== 32'h5678) begin failures++; $display("FAIL div0_lo got=%h exp=5678", lo); end
   endtask

   task automatic test_mflo_stall;
      int n;
      @(negedge clk);
      start = 1'b1; md_op = OP_MULT; rs_val = 32'h00010000; rt_val = 32'h00030001;
      @(negedge clk);
      md_op = OP_MFLO; #1;
      n = 0;
      while (stall_req && n < 64) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== 5) begin failures++; $display("FAIL mflo_stall_cycles got=%0d exp=5", n); end
      checks++; if (md_rdata !== 32'h00010000) begin failures++; $display("FAIL mflo_rdata got=%h exp=00010000", md_rdata); end
      checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mflo_stall_end got=%0b exp=0", stall_req); end
      md_op = OP_MFHI; #1;
      checks++; if (md_rdata !== 32'h00000003) begin failures++; $display("FAIL mfhi_rdata got=%h exp=00000003", md_rdata); end
      start = 1'b0; md_op = OP_NONE;
   endtask

   task automatic test_back_to_back;
      int n;
      @(negedge clk);
      start = 1'b1; md_op = OP_MULT; rs_val = 32'h5; rt_val = 32'hFFFFFFFD;
      @(negedge clk);
      // DIV held in E behind the MULT; its operands must not disturb the product.
      md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; #1;
      n = 0;
      while (stall_req && n < 64) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== 5) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=5", n); end
      checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL b2b_mult_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL b2b_mult_lo got=%h exp=fffffff1", lo); end
      @(negedge clk);
      start = 1'b0; md_op = OP_NONE;
      count_busy(n);
      checks++; if (n !== 10) begin failures++; $display("FAIL b2b_div_busy got=%0d exp=10", n); end
      checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_div_lo got=%h exp=0000000e", lo); end
      checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_div_hi got=%h exp=00000002", hi); end
   endtask

   task automatic test_reset_abort;
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%0b exp=1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
      repeat (10) @(negedge clk);
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL abort_no_late_write got=%h exp=0", lo); end
      issue(OP_MTLO, 32'hA5, 32'h0);
      checks++; if (lo !== 32'hA5) begin failures++; $display("FAIL abort_mtlo got=%h exp=000000a5", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL abort_mtlo_hi got=%h exp=0", hi); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_divu();
      test_div_overflow();
      test_div_by_zero();
      test_mflo_stall();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers. Sits in the E stage of the 5-stage MIPS pipeline, beside the ALU.
- Sequences MULT/MULTU/DIV/DIVU over a fixed number of busy cycles and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request so the hazard logic freezes F/D while the E-stage instruction needs the unit before it is free.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  E-stage MD operation code (see Behaviour).
- start  input  1  E-stage instruction is valid and not flushed; qualifies md_op.
- rs_val  input  WIDTH  forwarded rs operand.
- rt_val  input  WIDTH  forwarded rt operand.
- busy  output  1  unit is computing.
- stall_req  output  1  stall request to the hazard unit.
- md_rdata  output  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise; combinational from the registers.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Ports clk and reset: one clock; reset is synchronous and active-high.
- md_op encodings: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9-15 behave as MD_NONE.
- md_use = start && (md_op != MD_NONE).
- State machine:
  - States: IDLE, MUL_BUSY, DIV_BUSY.
  - Down-counter: cnt, width of clog2 of the larger of MULT_CYCLES and DIV_CYCLES, plus 1.
- Reset: state=IDLE, cnt=0, hi=0, lo=0, busy=0. stall_req follows its equation (0 when start=0). Reset during a busy operation aborts it with no HI/LO update.
- IDLE, md_use with MULT/MULTU at edge T:
  - Latch rs_val and rt_val.
  - Go to MUL_BUSY with cnt=MULT_CYCLES.
  - DIV/DIVU works the same way: go to DIV_BUSY with cnt=DIV_CYCLES.
- Busy states:
  - cnt decrements each cycle.
  - At the edge where cnt==1: write HI/LO from the latched operands and return to IDLE.
  - busy is high for exactly N cycles after the accepting edge. The new HI/LO are visible in the cycle after busy falls.
- Arithmetic:
  - MULT: signed 64-bit product; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 64-bit product; same HI/LO split.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0: HI/LO unchanged, but the busy period still elapses.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: accepted only when IDLE and md_use. HI (or LO) takes rs_val at that edge; no busy period.
- MFHI/MFLO: md_rdata reflects the register combinationally. The hazard unit holds the instruction while stall_req is high.
- stall_req = md_use && (busy || ((md_op is MULT/MULTU/DIV/DIVU) && state==IDLE... )). Final decided form:
  - stall_req = md_use && busy.
  - A start op is accepted the same edge it appears in IDLE, so it does not stall itself. Only a following MD instruction stalls.
- md_use while busy: ignored; no state change. The stall guarantees it is re-presented.
- start=0 never changes state. Non-MD instructions proceed while busy, with no stall.

Decomposition:
- Shared package md_defs:
  - md_op codes.
  - State encoding.
  - Default cycle counts.
- One natural sub-module: md_arith, combinational.
  - Inputs: latched operands and operation kind.
  - Outputs: 64-bit {hi,lo} result and a div_by_zero flag.
- The FSM, counter and HI/LO registers stay in mul_div_unit.

Test Plan:
- MULT, rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by 0 after MTHI 0x1234, MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
- MULT followed by MFLO held in E -> stall_req=1 for 5 cycles; then md_rdata=product low word and stall_req=0.
- DIVU started, reset asserted on the 4th busy cycle -> next cycle busy=0, hi=lo=0, state IDLE; a later MTLO 0xA5 gives lo=0xA5.
